// File: rtl/bp_pkg.sv
// Shared types for the branch-predictor update scheduler.
// Update record, scheduler states and sweep constants.
package bp_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic        is_br;
        logic        taken;
        logic [31:0] target;
    } bp_update_t;

    typedef enum logic {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } bp_sched_state_t;

    localparam logic BP_SWEEP_IS_BR = 1'b0;

endpackage

// File: rtl/bp_update_scheduler_if.sv
// Update bus: valid/ready handshake plus predictor update fields.
// The issue/sink modports carry no ready since the predictor never stalls.
interface bp_update_if;
    import bp_pkg::*;

    logic        valid;
    logic        ready;
    logic [31:0] pc;
    logic        is_br;
    logic        taken;
    logic [31:0] target;

    modport master (
        output valid, pc, is_br, taken, target,
        input  ready
    );

    modport slave (
        input  valid, pc, is_br, taken, target,
        output ready
    );

    modport issue (
        output valid, pc, is_br, taken, target
    );

    modport sink (
        input valid, pc, is_br, taken, target
    );

endinterface

// File: rtl/bp_update_scheduler_fifo.sv
// Update queue with two ordered write ports (w0 lands before w1),
// one pop port and an occupancy count.
module bp_update_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       w0_en,
    input  bp_update_t                 w0_data,
    input  logic                       w1_en,
    input  bp_update_t                 w1_data,
    input  logic                       pop,
    output bp_update_t                 head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    bp_update_t       mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    w1_ptr;

    assign w1_ptr = wr_ptr + PW'(w0_en);
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (w0_en) mem[wr_ptr] <= w0_data;
        if (w1_en) mem[w1_ptr] <= w1_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(w0_en) + PW'(w1_en);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + CW'(w0_en) + CW'(w1_en) - CW'(pop);
        end
    end

endmodule

// File: rtl/bp_update_scheduler.sv
// Owns the predictor update port: merges two update sources through a
// queue and clears every predictor entry after reset or on flush.
module bp_update_scheduler
    import bp_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 6,
    parameter int ADDR_SIZE  = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    bp_update_if.slave src0,
    bp_update_if.slave src1,
    input  logic       flush_req,
    bp_update_if.issue upd,
    output logic       busy
);

    localparam int CW = $clog2(DEPTH) + 1;

    bp_sched_state_t         state;
    logic [ADDR_WIDTH-1:0]   sweep_idx;
    logic                    rr;
    logic [CW-1:0]           count;
    bp_update_t              head;
    bp_update_t              d0;
    bp_update_t              d1;
    logic                    run;
    logic                    free_ge2;
    logic                    free_eq1;
    logic                    fire0;
    logic                    fire1;
    logic                    contest;
    logic                    pop;

    assign run      = (state == RUN);
    assign busy     = !run;
    assign free_ge2 = (count <= CW'(DEPTH - 2));
    assign free_eq1 = (count == CW'(DEPTH - 1));

    // With one slot left the grant depends on the other side's valid.
    assign src0.ready = run & (free_ge2 | (free_eq1 & (!src1.valid | !rr)));
    assign src1.ready = run & (free_ge2 | (free_eq1 & (!src0.valid | rr)));

    assign fire0   = src0.valid & src0.ready;
    assign fire1   = src1.valid & src1.ready;
    assign contest = run & free_eq1 & src0.valid & src1.valid;
    assign pop     = run & (count != '0);

    assign d0 = '{pc: src0.pc, is_br: src0.is_br,
                  taken: src0.taken, target: src0.target};
    assign d1 = '{pc: src1.pc, is_br: src1.is_br,
                  taken: src1.taken, target: src1.target};

    bp_update_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (flush_req),
        .w0_en   (fire0),
        .w0_data (d0),
        .w1_en   (fire1),
        .w1_data (d1),
        .pop     (pop),
        .head    (head),
        .count   (count)
    );

    always_comb begin
        upd.valid  = 1'b0;
        upd.pc     = '0;
        upd.is_br  = 1'b0;
        upd.taken  = 1'b0;
        upd.target = '0;
        if (!run) begin
            upd.valid  = rst_n;
            upd.pc     = {{(30-ADDR_WIDTH){1'b0}}, sweep_idx, 2'b00};
            upd.is_br  = BP_SWEEP_IS_BR;
        end else begin
            upd.valid  = pop;
            upd.pc     = head.pc;
            upd.is_br  = head.is_br;
            upd.taken  = head.taken;
            upd.target = head.target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SWEEP;
            sweep_idx <= '0;
            rr        <= 1'b0;
        end else begin
            if (contest) rr <= ~rr;
            if (flush_req) begin
                state     <= SWEEP;
                sweep_idx <= '0;
            end else begin
                unique case (state)
                    SWEEP: begin
                        sweep_idx <= sweep_idx + 1'b1;
                        if (sweep_idx == ADDR_WIDTH'(ADDR_SIZE - 1)) begin
                            state     <= RUN;
                            sweep_idx <= '0;
                        end
                    end
                    RUN: ;
                    default: state <= SWEEP;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Scoreboard bench for bp_update_scheduler: directed stimulus pushes
// hand-derived updates; a negedge monitor pops and compares.
module tb_bp_update_scheduler;
    import bp_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush_req = 1'b0;
    logic busy;

    int total = 0;
    int bad = 0;
    bp_update_t exp_q[$];

    bp_update_if src0_if ();
    bp_update_if src1_if ();
    bp_update_if upd_if ();

    bp_update_scheduler #(.DEPTH(4), .ADDR_WIDTH(6), .ADDR_SIZE(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src0      (src0_if),
        .src1      (src1_if),
        .flush_req (flush_req),
        .upd       (upd_if),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [71:0] act,
                       input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic bp_update_t sw(input int i);
        bp_update_t u;
        u.pc     = 32'(i) << 2;
        u.is_br  = 1'b0;
        u.taken  = 1'b0;
        u.target = '0;
        return u;
    endfunction

    function automatic bp_update_t mk0(input int n);
        bp_update_t u;
        u.pc     = 32'h1000 + 32'(n) * 4;
        u.is_br  = 1'b1;
        u.taken  = n[0];
        u.target = 32'h3000 + 32'(n) * 8;
        return u;
    endfunction

    function automatic bp_update_t mk1(input int n);
        bp_update_t u;
        u.pc     = 32'h2000 + 32'(n) * 4;
        u.is_br  = n[0];
        u.taken  = 1'b1;
        u.target = 32'h4000 + 32'(n) * 8;
        return u;
    endfunction

    task automatic push_sweep(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(sw(i));
    endtask

    task automatic drv0(input logic v, input bp_update_t u);
        src0_if.valid  = v;
        src0_if.pc     = u.pc;
        src0_if.is_br  = u.is_br;
        src0_if.taken  = u.taken;
        src0_if.target = u.target;
    endtask

    task automatic drv1(input logic v, input bp_update_t u);
        src1_if.valid  = v;
        src1_if.pc     = u.pc;
        src1_if.is_br  = u.is_br;
        src1_if.taken  = u.taken;
        src1_if.target = u.target;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic busy_len(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk(name, 72'(n), 72'd64);
    endtask

    always @(negedge clk) begin
        if (upd_if.valid) begin
            bp_update_t got;
            got = '{pc: upd_if.pc, is_br: upd_if.is_br,
                    taken: upd_if.taken, target: upd_if.target};
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_upd: got %0h want none", got);
            end else begin
                chk("upd", 72'(got), 72'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int n0;
        int n1;
        logic g0;
        logic g1;
        upd_if.ready = 1'b1;
        drv0(1'b0, '0);
        drv1(1'b0, '0);

        repeat (3) @(negedge clk);
        chk("rst_valid", 72'(upd_if.valid), 72'd0);
        chk("rst_ready", 72'({src0_if.ready, src1_if.ready}), 72'd0);
        chk("rst_busy", 72'(busy), 72'd1);

        push_sweep(64);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            chk("sweep_busy_rdy",
                72'({busy, src0_if.ready, src1_if.ready}), 72'b100);
        end
        @(negedge clk);
        chk("busy_fall", 72'(busy), 72'd0);

        step();
        drv0(1'b1, '{pc: 32'h100, is_br: 1'b1, taken: 1'b1, target: 32'h200});
        @(negedge clk);
        chk("single_rdy", 72'(src0_if.ready), 72'd1);
        exp_q.push_back('{pc: 32'h100, is_br: 1'b1, taken: 1'b1,
                          target: 32'h200});
        step();
        drv0(1'b0, '0);
        @(negedge clk);
        chk("single_lat", 72'(upd_if.valid), 72'd1);
        step();
        @(negedge clk);
        chk("single_gone", 72'(upd_if.valid), 72'd0);

        n0 = 0;
        n1 = 0;
        for (int k = 1; k <= 26; k++) begin
            step();
            drv0(1'b1, mk0(n0));
            drv1(k <= 20, mk1(n1));
            @(negedge clk);
            if (k <= 2) begin
                g0 = 1'b1;
                g1 = 1'b1;
            end else if (k <= 20) begin
                g0 = k[0];
                g1 = !k[0];
            end else begin
                g0 = 1'b1;
                g1 = 1'b0;
            end
            chk($sformatf("rdy0_k%0d", k), 72'(src0_if.ready), 72'(g0));
            chk($sformatf("rdy1_k%0d", k), 72'(src1_if.ready), 72'(g1));
            if (g0) begin
                exp_q.push_back(mk0(n0));
                n0++;
            end
            if (g1) begin
                exp_q.push_back(mk1(n1));
                n1++;
            end
        end
        step();
        drv0(1'b0, '0);
        drv1(1'b0, '0);
        repeat (4) @(negedge clk);
        chk("drained", 72'(upd_if.valid), 72'd0);

        step();
        drv0(1'b1, mk0(100));
        drv1(1'b1, mk1(100));
        @(negedge clk);
        chk("fl_rdy_a", 72'({src0_if.ready, src1_if.ready}), 72'b11);
        exp_q.push_back(mk0(100));
        exp_q.push_back(mk1(100));
        step();
        drv0(1'b1, mk0(101));
        drv1(1'b1, mk1(101));
        @(negedge clk);
        chk("fl_rdy_b", 72'({src0_if.ready, src1_if.ready}), 72'b11);
        step();
        drv0(1'b0, '0);
        drv1(1'b0, '0);
        flush_req = 1'b1;
        @(negedge clk);
        chk("fl_busy_pre", 72'(busy), 72'd0);
        push_sweep(31);
        step();
        flush_req = 1'b0;
        @(negedge clk);
        chk("fl_sweep_start",
            72'({busy, upd_if.valid, upd_if.pc}), {38'd0, 1'b1, 1'b1, 32'h0});

        repeat (30) step();
        flush_req = 1'b1;
        push_sweep(64);
        @(negedge clk);
        chk("sw_idx30", 72'(upd_if.pc), 72'h78);
        step();
        flush_req = 1'b0;
        busy_len("restart_len");

        step();
        drv0(1'b1, mk0(200));
        drv1(1'b1, mk1(200));
        @(negedge clk);
        chk("ar_rdy", 72'({src0_if.ready, src1_if.ready}), 72'b11);
        step();
        drv0(1'b0, '0);
        drv1(1'b0, '0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 72'(upd_if.valid), 72'd0);
        chk("ar_busy", 72'(busy), 72'd1);
        repeat (2) @(posedge clk);
        push_sweep(64);
        #1;
        rst_n = 1'b1;
        busy_len("rst_sweep_len");

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 72'(exp_q.size()), 72'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
